core_launch_ctrl: RTL and testbench

//  Responder side of the top-level start/processorReady/processDone handshake driven by the bench/host.

---
 rtl/multicore_pkg.sv | 16 +
 rtl/done_collector.sv | 40 ++++
 rtl/core_launch_ctrl.sv | 128 ++++++++++++
 tb/tb_core_launch_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/multicore_pkg.sv
// Shared definitions for the multicore launch/collect control path:
// FSM state encoding and default sizing of the core array.
package multicore_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_LAUNCH = 2'd1;
    localparam state_t ST_RUN    = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

    localparam int DEFAULT_CORE_COUNT     = 6;
    localparam int DEFAULT_TIMEOUT_CYCLES = 100000;
    localparam int DEFAULT_CNT_W          = 32;

endpackage

// File: rtl/done_collector.sv
// Sticky per-core completion record for one run, plus the "every enabled core
// has finished" decision including bits arriving this very cycle.
module done_collector #(
    parameter int N = 6
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_clear,
    input  logic         i_capture,
    input  logic [N-1:0] i_enable_mask,
    input  logic [N-1:0] i_core_done,
    output logic [N-1:0] o_done_mask,
    output logic         o_all_done
);

    logic [N-1:0] r_done;
    logic [N-1:0] w_merged;

    // Sticky done record; bits of disabled cores are masked off before capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_done <= {N{1'b0}};
        end else if (i_clear) begin
            r_done <= {N{1'b0}};
        end else if (i_capture) begin
            r_done <= r_done | (i_core_done & i_enable_mask);
        end else begin
            r_done <= r_done;
        end
    end

    // Completion looks ahead at this cycle's pulses so DONE follows the last pulse directly.
    always_comb begin
        w_merged   = r_done | (i_core_done & i_enable_mask);
        o_all_done = ((w_merged & i_enable_mask) == i_enable_mask);
    end

    assign o_done_mask = r_done;

endmodule

// File: rtl/core_launch_ctrl.sv
// Responder side of the start/processorReady/processDone handshake: launches the
// enabled cores, collects their done pulses and reports run length / watchdog expiry.
module core_launch_ctrl
    import multicore_pkg::*;
#(
    parameter int CORE_COUNT     = DEFAULT_CORE_COUNT,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEFAULT_CNT_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CORE_COUNT-1:0] coreEnableMask,
    input  logic [CORE_COUNT-1:0] coreDone,
    output logic [CORE_COUNT-1:0] coreStart,
    output logic                  processorReady,
    output logic                  processDone,
    output logic                  timeoutFlag,
    output logic [CORE_COUNT-1:0] doneMask,
    output logic [CNT_W-1:0]      cycleCount
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic             WDOG_EN  = (TIMEOUT_CYCLES > 0) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] TO_LIMIT = (TIMEOUT_CYCLES > 0) ?
                                            CNT_W'(TIMEOUT_CYCLES - 1) : {CNT_W{1'b0}};

    state_t                r_state;
    state_t                w_next_state;
    logic [CORE_COUNT-1:0] r_mask;
    logic [CNT_W-1:0]      r_count;
    logic                  r_timeout;
    logic                  w_accept;
    logic                  w_all_done;
    logic                  w_wdog_hit;
    logic                  w_in_run;

    // A start is only honoured while the handshake advertises readiness.
    always_comb begin
        w_accept   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
        w_in_run   = (r_state == ST_RUN);
        w_wdog_hit = WDOG_EN && (r_count >= TO_LIMIT);
    end

    done_collector #(
        .N (CORE_COUNT)
    ) u_done_collector (
        .clock         (clock),
        .reset         (reset),
        .i_clear       (w_accept),
        .i_capture     (w_in_run),
        .i_enable_mask (r_mask),
        .i_core_done   (coreDone),
        .o_done_mask   (doneMask),
        .o_all_done    (w_all_done)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; completion takes priority over the watchdog.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   w_next_state = start ? ST_LAUNCH : ST_IDLE;
            ST_LAUNCH: w_next_state = (r_mask == {CORE_COUNT{1'b0}}) ? ST_DONE : ST_RUN;
            ST_RUN:    w_next_state = (w_all_done || w_wdog_hit) ? ST_DONE : ST_RUN;
            ST_DONE:   w_next_state = start ? ST_LAUNCH : ST_DONE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Enable mask is captured together with the accepted start.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_mask <= {CORE_COUNT{1'b0}};
        end else if (w_accept) begin
            r_mask <= coreEnableMask;
        end else begin
            r_mask <= r_mask;
        end
    end

    // Run-length counter and watchdog flag; frozen outside RUN until the next launch.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count   <= {CNT_W{1'b0}};
            r_timeout <= 1'b0;
        end else if (w_accept) begin
            r_count   <= {CNT_W{1'b0}};
            r_timeout <= 1'b0;
        end else if (w_in_run) begin
            r_count   <= (r_count == CNT_MAX) ? r_count : (r_count + CNT_ONE);
            r_timeout <= w_wdog_hit && !w_all_done;
        end else begin
            r_count   <= r_count;
            r_timeout <= r_timeout;
        end
    end

    // Moore output decode from the registered state.
    always_comb begin
        coreStart      = {CORE_COUNT{1'b0}};
        processorReady = 1'b0;
        processDone    = 1'b0;
        case (r_state)
            ST_IDLE:   processorReady = 1'b1;
            ST_LAUNCH: coreStart = r_mask;
            ST_RUN:    processorReady = 1'b0;
            ST_DONE: begin
                processorReady = 1'b1;
                processDone    = 1'b1;
            end
            default:   processorReady = 1'b0;
        endcase
    end

    assign timeoutFlag = r_timeout;
    assign cycleCount  = r_count;

endmodule

// File: tb/tb_core_launch_ctrl.sv
// Scoreboard bench for core_launch_ctrl: stimulus queues expected launches and run
// results; a negedge monitor pops and compares whenever the DUT presents them.
module tb_core_launch_ctrl;

    localparam int NC = 6;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [NC-1:0] coreEnableMask;
    logic [NC-1:0] coreDone;
    logic [NC-1:0] coreStart;
    logic          processorReady;
    logic          processDone;
    logic          timeoutFlag;
    logic [NC-1:0] doneMask;
    logic [31:0]   cycleCount;

    typedef struct {
        logic [NC-1:0] cs;
        int            at;
    } launch_t;

    typedef struct {
        logic [NC-1:0] dm;
        logic [31:0]   cnt;
        logic          to;
        int            at;
    } done_t;

    launch_t launch_q[$];
    done_t   done_q[$];
    launch_t mon_le;
    done_t   mon_de;
    int      cyc = 0;
    int      checks = 0;
    int      errors = 0;
    int      sched[NC];
    logic    prev_done = 1'b0;

    core_launch_ctrl #(
        .CORE_COUNT     (NC),
        .TIMEOUT_CYCLES (20),
        .CNT_W          (32)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .coreEnableMask (coreEnableMask),
        .coreDone       (coreDone),
        .coreStart      (coreStart),
        .processorReady (processorReady),
        .processDone    (processDone),
        .timeoutFlag    (timeoutFlag),
        .doneMask       (doneMask),
        .cycleCount     (cycleCount)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_coreStart"}, 32'(coreStart), 32'h0);
        check({tag, "_processDone"}, 32'(processDone), 32'h0);
        check({tag, "_timeoutFlag"}, 32'(timeoutFlag), 32'h0);
        check({tag, "_doneMask"}, 32'(doneMask), 32'h0);
        check({tag, "_cycleCount"}, cycleCount, 32'h0);
        check({tag, "_processorReady"}, 32'(processorReady), 32'h1);
    endtask

    // One run: launch with mask, pulse cores per sched[] (RUN cycle index, 0 = never).
    // exp_lat < 0 means no completion is expected; hold_from/reset_at are RUN cycles (0 = unused).
    task automatic run_case(input logic [NC-1:0] mask, input logic [NC-1:0] exp_dm,
                            input int exp_cnt, input logic exp_to, input int exp_lat,
                            input int hold_from, input int reset_at);
        int            n;
        logic [NC-1:0] cd;
        launch_t       le;
        done_t         de;
        if (start !== 1'b1) begin
            @(posedge clock); #1;
        end
        start          = 1'b1;
        coreEnableMask = mask;
        n              = cyc + 1;
        if (mask != '0) begin
            le.cs = mask;
            le.at = n;
            launch_q.push_back(le);
        end
        if (exp_lat > 0) begin
            de.dm  = exp_dm;
            de.cnt = exp_cnt;
            de.to  = exp_to;
            de.at  = n + exp_lat;
            done_q.push_back(de);
        end
        @(posedge clock); #1;
        start          = 1'b0;
        coreEnableMask = ~mask;
        check("launch_processDone", 32'(processDone), 32'h0);
        check("launch_processorReady", 32'(processorReady), 32'h0);
        check("launch_cycleCount", cycleCount, 32'h0);
        check("launch_doneMask", 32'(doneMask), 32'h0);
        check("launch_timeoutFlag", 32'(timeoutFlag), 32'h0);
        for (int k = 1; k <= 30; k++) begin
            @(posedge clock); #1;
            if (reset) begin
                reset    = 1'b0;
                coreDone = '0;
                check_idle("midrun_reset");
                break;
            end
            if (processDone) begin
                coreDone = '0;
                break;
            end
            for (int c = 0; c < NC; c++) cd[c] = (sched[c] == k);
            coreDone = cd;
            if (k == hold_from) start = 1'b1;
            if (k == reset_at) reset = 1'b1;
        end
        coreDone = '0;
    endtask

    // Monitor: compares every coreStart pulse and every processDone rise against the queues.
    always @(negedge clock) begin
        if (reset === 1'b0) begin
            if (!$isunknown(coreStart) && coreStart != '0) begin
                if (launch_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_launch: got coreStart %0h at cycle %0d, none expected",
                             coreStart, cyc);
                end else begin
                    mon_le = launch_q.pop_front();
                    check("coreStart", 32'(coreStart), 32'(mon_le.cs));
                    check("launch_cycle", cyc, mon_le.at);
                end
            end
            if (processDone === 1'b1 && prev_done !== 1'b1) begin
                if (done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got processDone rise at cycle %0d, none expected", cyc);
                end else begin
                    mon_de = done_q.pop_front();
                    check("doneMask", 32'(doneMask), 32'(mon_de.dm));
                    check("cycleCount", cycleCount, mon_de.cnt);
                    check("timeoutFlag", 32'(timeoutFlag), 32'(mon_de.to));
                    check("done_cycle", cyc, mon_de.at);
                    check("done_processorReady", 32'(processorReady), 32'h1);
                end
            end
        end
        prev_done = processDone;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, at cycle %0d", cyc);
        $fatal(1, "global timeout");
    end

    initial begin
        reset          = 1'b1;
        start          = 1'b0;
        coreEnableMask = '0;
        coreDone       = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check_idle("reset");

        sched = '{3, 5, 5, 7, 9, 12};
        run_case(6'h3F, 6'h3F, 12, 1'b0, 13, 0, 0);

        sched = '{2, 3, 6, 0, 0, 0};
        run_case(6'h05, 6'h05, 6, 1'b0, 7, 0, 0);

        sched = '{1, 2, 3, 4, 0, 5};
        run_case(6'h3F, 6'h2F, 20, 1'b1, 21, 0, 0);

        sched = '{20, 20, 20, 20, 20, 20};
        run_case(6'h3F, 6'h3F, 20, 1'b0, 21, 0, 0);

        sched = '{4, 4, 4, 4, 4, 4};
        run_case(6'h3F, 6'h3F, 4, 1'b0, 5, 2, 0);
        sched = '{0, 2, 0, 0, 3, 0};
        run_case(6'h12, 6'h12, 3, 1'b0, 4, 0, 0);

        sched = '{0, 0, 0, 0, 0, 0};
        run_case(6'h00, 6'h00, 0, 1'b0, 1, 0, 0);

        sched = '{10, 10, 10, 10, 10, 10};
        run_case(6'h3F, 6'h00, 0, 1'b0, -1, 0, 4);

        sched = '{1, 0, 0, 0, 0, 0};
        run_case(6'h01, 6'h01, 1, 1'b0, 2, 0, 0);

        repeat (5) @(posedge clock);
        #1;
        check("launch_queue_left", 32'(launch_q.size()), 32'h0);
        check("done_queue_left", 32'(done_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
